muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_muldiv_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential 32x32 signed multiply / divide. Works on magnitudes with one iteration
// per cycle, then applies the sign correction in a final cycle.
module muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] RA,
   input  logic [31:0] RB,
   output logic [63:0] RZ,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   // state | meaning
   // IDLE  | waiting for start; divide-by-zero is resolved here in one cycle
   // CALC  | 32 shift-add (mul) or restoring shift-subtract (div) iterations
   // FIX   | sign correction, result load, done pulse
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] b_q, b_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic        op_q, op_d;
   logic [63:0] rz_q, rz_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;

   logic        div_zero_req;
   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic [32:0] rem_diff;
   logic [63:0] prod_mag;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign div_zero_req = start && op && (RB == 32'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         op_q    <= 1'b0;
         rz_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         op_q    <= op_d;
         rz_q    <= rz_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !div_zero_req) state_d = CALC;
         CALC:    if (cnt_q == 6'd31) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // {hi, lo} is the product register for mul and {remainder, quotient} for div.
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
      rem_sh   = {hi_q, lo_q[31]};
      rem_diff = rem_sh - {1'b0, b_q};
      prod_mag = {hi_q, lo_q};
      quo_fix  = (sa_q ^ sb_q) ? (~lo_q + 32'd1) : lo_q;
      rem_fix  = sa_q ? (~hi_q + 32'd1) : hi_q;

      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      b_d    = b_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      op_d   = op_q;
      rz_d   = rz_q;
      dbz_d  = dbz_q;
      done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (div_zero_req) begin
               rz_d   = {RA, 32'hFFFF_FFFF};
               dbz_d  = 1'b1;
               done_d = 1'b1;
            end else if (start) begin
               hi_d  = '0;
               lo_d  = RA[31] ? (~RA + 32'd1) : RA;
               b_d   = RB[31] ? (~RB + 32'd1) : RB;
               sa_d  = RA[31];
               sb_d  = RB[31];
               op_d  = op;
               cnt_d = '0;
               dbz_d = 1'b0;
            end
         end
         CALC: begin
            cnt_d = cnt_q + 6'd1;
            if (!op_q) begin
               hi_d = mul_sum[32:1];
               lo_d = {mul_sum[0], lo_q[31:1]};
            end else if (rem_sh >= {1'b0, b_q}) begin
               hi_d = rem_diff[31:0];
               lo_d = {lo_q[30:0], 1'b1};
            end else begin
               hi_d = rem_sh[31:0];
               lo_d = {lo_q[30:0], 1'b0};
            end
         end
         FIX: begin
            if (!op_q) rz_d = (sa_q ^ sb_q) ? (~prod_mag + 64'd1) : prod_mag;
            else       rz_d = {rem_fix, quo_fix};
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy        = (state_q != IDLE);
      RZ          = rz_q;
      done        = done_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a vector table of signed mul/div cases plus
// sequences for ignored start, mid-operation reset and back-to-back operation.
module tb_muldiv_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] RA;
   logic [31:0] RB;
   logic [63:0] RZ;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string       name;
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] rz;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   muldiv_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .RA(RA), .RB(RB),
      .RZ(RZ), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Presents a request at the next edge (edge T), then scrambles the inputs.
   task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
      op    = o;
      RA    = a;
      RB    = b;
      start = 1'b1;
      tick();
      cyc   = 0;
      start = 1'b0;
      RA    = $urandom;
      RB    = $urandom;
      op    = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_rz,
                            input logic exp_dbz, input bit post);
      chk({tag, " busy_at_T"}, 64'(busy), 64'(exp_lat != 0));
      while (!done && cyc < 60) tick();
      chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, " RZ"}, RZ, exp_rz);
      chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
      if (post) begin
         tick();
         chk({tag, " done_clear"}, 64'(done), 64'd0);
         chk({tag, " busy_after"}, 64'(busy), 64'd0);
         chk({tag, " RZ_hold"}, RZ, exp_rz);
      end
   endtask

   initial begin
      vecs[0]  = '{"mul 8*8",          1'b0, 32'd8,          32'd8,          64'h0000_0000_0000_0040, 1'b0, 33};
      vecs[1]  = '{"mul -8*8",         1'b0, 32'hFFFF_FFF8,  32'd8,          64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 33};
      vecs[2]  = '{"mul -8*-8",        1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFF8,  64'h0000_0000_0000_0040, 1'b0, 33};
      vecs[3]  = '{"mul 0*x",          1'b0, 32'd0,          32'd12345,      64'h0000_0000_0000_0000, 1'b0, 33};
      vecs[4]  = '{"mul min*min",      1'b0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0, 33};
      vecs[5]  = '{"mul max*-1",       1'b0, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0001, 1'b0, 33};
      vecs[6]  = '{"div 5/0",          1'b1, 32'd5,          32'd0,          64'h0000_0005_FFFF_FFFF, 1'b1, 0};
      vecs[7]  = '{"div 36/6",         1'b1, 32'd36,         32'd6,          64'h0000_0000_0000_0006, 1'b0, 33};
      vecs[8]  = '{"div -7/2",         1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33};
      vecs[9]  = '{"div 7/-2",         1'b1, 32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 1'b0, 33};
      vecs[10] = '{"div 100/7",        1'b1, 32'd100,        32'd7,          64'h0000_0002_0000_000E, 1'b0, 33};
      vecs[11] = '{"div 3/10",         1'b1, 32'd3,          32'd10,         64'h0000_0003_0000_0000, 1'b0, 33};
      vecs[12] = '{"div min/min",      1'b1, 32'h8000_0000,  32'h8000_0000,  64'h0000_0000_0000_0001, 1'b0, 33};
      vecs[13] = '{"div -1/0",         1'b1, 32'hFFFF_FFFF,  32'd0,          64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0};

      reset = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      RA    = '0;
      RB    = '0;
      #12;
      chk("reset RZ", RZ, 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset dbz", 64'(div_by_zero), 64'd0);
      tick();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(vecs[i].name, vecs[i].lat, vecs[i].rz, vecs[i].dbz, 1'b1);
      end

      // start pulsed while busy must be ignored
      launch(1'b0, 32'd3, 32'd5);
      repeat (4) tick();
      op    = 1'b1;
      RA    = 32'd100;
      RB    = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ignore_start", 33, 64'd15, 1'b0, 1'b1);
      repeat (3) tick();
      chk("ignore_start no second op", 64'(busy), 64'd0);

      // reset mid-operation aborts and clears, start ignored while reset low
      launch(1'b1, 32'd5, 32'd0);
      wait_done("pre_reset dbz", 0, 64'h0000_0005_FFFF_FFFF, 1'b1, 1'b1);
      launch(1'b0, 32'd3, 32'd5);
      repeat (10) tick();
      chk("mid_op busy", 64'(busy), 64'd1);
      chk("mid_op RZ held", RZ, 64'h0000_0005_FFFF_FFFF);
      #2 reset = 1'b0;
      #1;
      chk("async reset RZ", RZ, 64'd0);
      chk("async reset busy", 64'(busy), 64'd0);
      chk("async reset dbz", 64'(div_by_zero), 64'd0);
      op    = 1'b1;
      RA    = 32'd9;
      RB    = 32'd0;
      start = 1'b1;
      repeat (3) tick();
      chk("start in reset busy", 64'(busy), 64'd0);
      chk("start in reset done", 64'(done), 64'd0);
      chk("start in reset RZ", RZ, 64'd0);
      start = 1'b0;
      reset = 1'b1;
      tick();
      launch(1'b1, 32'd36, 32'd6);
      wait_done("after_reset div", 33, 64'h0000_0000_0000_0006, 1'b0, 1'b1);

      // back-to-back: new start in the done cycle
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("b2b div min/-1", 33, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
      launch(1'b0, 32'hFFFF_FFF8, 32'd8);
      chk("b2b done cleared", 64'(done), 64'd0);
      chk("b2b RZ holds first", RZ, 64'h0000_0000_8000_0000);
      wait_done("b2b second mul", 33, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
